serial_adder: RTL



---
 rtl/serial_adder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB-first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             accept, last;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] res_nxt;

  serial_adder_fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // The final sum bit comes straight from the cell, so only WIDTH-1 bits
  // of partial result need storage.
  generate
    if (WIDTH > 1) begin : g_res
      logic [WIDTH-2:0] res_sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  res_sr <= '0;
        else if (state == SHIFT)  res_sr <= res_nxt[WIDTH-1:1];
      end
      assign res_nxt = {fa_s, res_sr};
    end else begin : g_res1
      assign res_nxt = fa_s;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= op_a;
      b_sr  <= op_b;
      carry <= cin;
      count <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_co;
      if (last) begin
        count <= '0;
        sum   <= res_nxt;
        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
        ovf   <= carry ^ fa_co;
`endif
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
